// File: rtl/async_input_ctrl.sv
// rtl/async_input_ctrl.sv - synchronized, debounced async inputs with a round-robin edge event slot
module async_input_ctrl #(
  parameter int N      = 4,
  parameter int STAGES = 2,
  parameter int DEB_W  = 8,
  localparam int CW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     async_in,
  input  logic [DEB_W-1:0] deb_limit,
  input  logic [N-1:0]     irq_mask,
  output logic [N-1:0]     state_out,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CW-1:0]    evt_chan,
  output logic             evt_rise,
  output logic [N-1:0]     ovf,
  input  logic [N-1:0]     ovf_clr,
  output logic             irq
);

  logic [STAGES-1:0] chain [N];
  logic [DEB_W-1:0]  cnt   [N];
  logic [N-1:0]      sync;
  logic [N-1:0]      chg;
  logic [N-1:0]      pend, pdir;
  logic [N-1:0]      pend_n, pdir_n, ovf_n, take;
  logic [CW-1:0]     last_grant, gidx;
  logic              found, load;

  // Bare flop chain per bit; stage 0 takes the pin, stage STAGES-1 feeds the debouncer.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) chain[i] <= '0;
      else     chain[i] <= {chain[i][STAGES-2:0], async_in[i]};
    end
  end

  always_comb begin
    sync = '0;
    chg  = '0;
    for (int i = 0; i < N; i++) begin
      sync[i] = chain[i][STAGES-1];
      chg[i]  = (sync[i] != state_out[i]) && (cnt[i] == deb_limit);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        cnt[i]       <= '0;
        state_out[i] <= 1'b0;
      end else if (sync[i] == state_out[i]) begin
        cnt[i] <= '0;
      end else if (chg[i]) begin
        cnt[i]       <= '0;
        state_out[i] <= sync[i];
      end else begin
        cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // Round-robin search begins just after the last granted channel.
  always_comb begin
    load  = !evt_valid || evt_ready;
    found = 1'b0;
    gidx  = '0;
    for (int k = 1; k <= N; k++) begin
      if (!found && pend[(int'(last_grant) + k) % N]) begin
        found = 1'b1;
        gidx  = CW'((int'(last_grant) + k) % N);
      end
    end
    take = '0;
    if (load && found) take[gidx] = 1'b1;
  end

  // A fresh edge always re-arms pend; it only counts as lost if the old one was not taken.
  always_comb begin
    pend_n = (pend & ~take) | chg;
    ovf_n  = (ovf & ~ovf_clr) | (chg & pend & ~take);
    pdir_n = pdir;
    for (int i = 0; i < N; i++) begin
      if (chg[i]) pdir_n[i] = sync[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend       <= '0;
      pdir       <= '0;
      ovf        <= '0;
      evt_valid  <= 1'b0;
      evt_chan   <= '0;
      evt_rise   <= 1'b0;
      irq        <= 1'b0;
      last_grant <= CW'(N - 1);
    end else begin
      pend <= pend_n;
      pdir <= pdir_n;
      ovf  <= ovf_n;
      irq  <= (|(pend & irq_mask)) | (evt_valid & irq_mask[evt_chan]);
      if (load) begin
        evt_valid <= found;
        if (found) begin
          evt_chan   <= gidx;
          evt_rise   <= pdir[gidx];
          last_grant <= gidx;
        end
      end
    end
  end

endmodule

// File: tb/tb_async_input_ctrl.sv
// tb/tb_async_input_ctrl.sv - scoreboard bench for async_input_ctrl with a queue-based reference model
module tb_async_input_ctrl;
  localparam int N = 4, STAGES = 2, DEB_W = 8, CW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     async_in;
  logic [DEB_W-1:0] deb_limit;
  logic [N-1:0]     irq_mask;
  logic [N-1:0]     state_out;
  logic             evt_valid;
  logic             evt_ready;
  logic [CW-1:0]    evt_chan;
  logic             evt_rise;
  logic [N-1:0]     ovf;
  logic [N-1:0]     ovf_clr;
  logic             irq;

  async_input_ctrl #(.N(N), .STAGES(STAGES), .DEB_W(DEB_W)) dut (
    .clk(clk), .rst(rst), .async_in(async_in), .deb_limit(deb_limit),
    .irq_mask(irq_mask), .state_out(state_out), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_chan(evt_chan), .evt_rise(evt_rise),
    .ovf(ovf), .ovf_clr(ovf_clr), .irq(irq)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct { int chan; bit rise; } evt_t;
  evt_t exp_q[$];
  evt_t seen_q[$];
  evt_t mon_e;

  bit [N-1:0] samp_q[$];
  int         run_m[N];
  bit [N-1:0] st_m, pend_m, pdir_m, ovf_m;
  bit         vld_m, rise_m, irq_m;
  int         chan_m, last_m;
  bit         run_chk = 0;
  int         acc_cnt = 0;

  // One clock edge of the reference behaviour, using the inputs present at that edge.
  task automatic model_step();
    bit [N-1:0] sy, chg;
    bit irqn;
    int g, c;
    if (rst) begin
      samp_q.delete(); exp_q.delete();
      foreach (run_m[i]) run_m[i] = 0;
      st_m = '0; pend_m = '0; pdir_m = '0; ovf_m = '0;
      vld_m = 0; chan_m = 0; rise_m = 0; irq_m = 0; last_m = N - 1;
      return;
    end
    sy  = (samp_q.size() == STAGES) ? samp_q[0] : '0;
    chg = '0;
    for (int i = 0; i < N; i++) begin
      if (sy[i] != st_m[i]) begin
        if (run_m[i] == int'(deb_limit)) chg[i] = 1;
        else run_m[i]++;
      end else run_m[i] = 0;
    end
    irqn = ((pend_m & irq_mask) != 0) || (vld_m && irq_mask[chan_m]);
    if (!vld_m || evt_ready) begin
      g = -1;
      for (int k = 1; k <= N; k++) begin
        c = (last_m + k) % N;
        if (g < 0 && pend_m[c]) g = c;
      end
      if (g >= 0) begin
        vld_m = 1; chan_m = g; rise_m = pdir_m[g]; last_m = g;
        exp_q.push_back('{g, pdir_m[g]});
        pend_m[g] = 0;
      end else vld_m = 0;
    end
    ovf_m = ovf_m & ~ovf_clr;
    for (int i = 0; i < N; i++) begin
      if (chg[i]) begin
        if (pend_m[i]) ovf_m[i] = 1;
        pend_m[i] = 1; pdir_m[i] = sy[i];
        st_m[i] = sy[i]; run_m[i] = 0;
      end
    end
    irq_m = irqn;
    samp_q.push_back(async_in);
    if (samp_q.size() > STAGES) void'(samp_q.pop_front());
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (run_chk) begin
      chk("state_out", state_out, st_m);
      chk("evt_valid", evt_valid, vld_m);
      if (vld_m) begin
        chk("slot_chan", evt_chan, chan_m);
        chk("slot_rise", evt_rise, rise_m);
      end
      chk("ovf", ovf, ovf_m);
      chk("irq", irq, irq_m);
    end
  end

  always @(negedge clk) begin
    if (run_chk && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL evt_unexpected: got chan %0d rise %0d, required no event", evt_chan, evt_rise);
      end else begin
        mon_e = exp_q.pop_front();
        chk("evt_chan", evt_chan, mon_e.chan);
        chk("evt_rise", evt_rise, mon_e.rise);
      end
      seen_q.push_back('{int'(evt_chan), evt_rise});
      acc_cnt++;
    end
  end

  int a0, k;
  bit irq_seen;

  initial begin
    rst = 1; async_in = '0; deb_limit = 3; irq_mask = '0; evt_ready = 1; ovf_clr = '0;
    repeat (3) cyc();
    run_chk = 1;
    @(negedge clk);
    chk("rst_state_out", state_out, 0);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_irq", irq, 0);

    // Step on ch0 first sampled at edge 1
    rst = 0; async_in = 4'b0001;
    repeat (5) cyc();
    @(negedge clk); chk("lat_state_e5", state_out[0], 0);
    cyc();
    @(negedge clk); chk("lat_state_e6", state_out[0], 1); chk("lat_valid_e6", evt_valid, 0);
    cyc();
    @(negedge clk); chk("lat_valid_e7", evt_valid, 1);
    chk("lat_chan_e7", evt_chan, 0); chk("lat_rise_e7", evt_rise, 1);
    repeat (3) cyc();

    // Glitch filtering on ch1
    a0 = acc_cnt;
    async_in = 4'b0011; repeat (3) cyc();
    async_in = 4'b0001; repeat (10) cyc();
    @(negedge clk); chk("glitch3_state", state_out, 4'b0001); chk("glitch3_events", acc_cnt - a0, 0);
    async_in = 4'b0011; repeat (4) cyc();
    async_in = 4'b0001; repeat (15) cyc();
    @(negedge clk); chk("pulse4_events", acc_cnt - a0, 2);
    chk("pulse4_last_chan", seen_q[seen_q.size()-1].chan, 1);

    // Simultaneous edges after a reset, round-robin from ch0
    async_in = '0; rst = 1; repeat (2) cyc();
    rst = 0; deb_limit = 0; repeat (4) cyc();
    a0 = acc_cnt;
    async_in = 4'b1101; repeat (8) cyc();
    @(negedge clk); chk("rr_count", acc_cnt - a0, 3);
    chk("rr_first", seen_q[a0].chan, 0);
    chk("rr_second", seen_q[a0+1].chan, 2);
    chk("rr_third", seen_q[a0+2].chan, 3);
    async_in = 4'b1100; repeat (6) cyc();
    @(negedge clk); chk("rr_wrap_ch0", seen_q[seen_q.size()-1].chan, 0);

    // Overflow on ch1 with the consumer stalled
    evt_ready = 0;
    async_in = 4'b1110; repeat (3) cyc();
    async_in = 4'b1100; repeat (3) cyc();
    async_in = 4'b1110; repeat (3) cyc();
    async_in = 4'b1100; repeat (3) cyc();
    @(negedge clk); chk("ovf_set", ovf, 4'b0010);
    chk("ovf_slot_chan", evt_chan, 1); chk("ovf_slot_rise", evt_rise, 1);
    ovf_clr = 4'b0010; cyc(); ovf_clr = '0;
    @(negedge clk); chk("ovf_clr", ovf, 0);
    a0 = acc_cnt;
    evt_ready = 1; repeat (6) cyc();
    @(negedge clk); chk("ovf_drain_count", acc_cnt - a0, 2);
    chk("ovf_pending_fall", seen_q[seen_q.size()-1].rise, 0);

    // Interrupt masking
    irq_mask = 4'b0100; irq_seen = 0;
    async_in = 4'b1110;
    for (int i = 0; i < 8; i++) begin cyc(); @(negedge clk); if (irq) irq_seen = 1; end
    chk("irq_masked_ch1", irq_seen, 0);
    async_in = 4'b1010;
    for (int i = 0; i < 8; i++) begin cyc(); @(negedge clk); if (irq) irq_seen = 1; end
    chk("irq_ch2_seen", irq_seen, 1);
    chk("irq_cleared", irq, 0);

    // Reset during a stalled handshake
    evt_ready = 0; async_in = 4'b1110; repeat (5) cyc();
    @(negedge clk); chk("pre_rst_valid", evt_valid, 1);
    rst = 1; cyc(); rst = 0;
    @(negedge clk);
    chk("mid_rst_state", state_out, 0); chk("mid_rst_valid", evt_valid, 0);
    chk("mid_rst_ovf", ovf, 0); chk("mid_rst_irq", irq, 0);
    a0 = acc_cnt; evt_ready = 1; repeat (10) cyc();
    @(negedge clk); chk("post_rst_events", acc_cnt - a0, 3);

    // Randomized traffic against the reference model
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) deb_limit = DEB_W'($urandom_range(0, 3));
      if (c % 200 == 0) irq_mask = N'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) begin
        k = $urandom_range(0, N - 1);
        async_in[k] = ~async_in[k];
      end
      evt_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 19) == 0) ? N'($urandom_range(0, 15)) : '0;
      rst       = ($urandom_range(0, 499) == 0);
      cyc();
    end
    rst = 0; evt_ready = 1; ovf_clr = '0;
    repeat (40) cyc();
    @(negedge clk); chk("drain_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
